// File: rtl/hex_record_parser.sv
// Intel HEX record decoder: parses ":LLAAAATT[DD..]CC" from a UART byte stream,
// verifies the checksum and replays the data bytes as addressed memory writes.
module hex_record_parser #(
  parameter int MAX_LEN = 16
) (
  input  logic        CLK_UART_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        rec_done_o,
  output logic        eof_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [1:0] E_CHAR = 2'd0;
  localparam logic [1:0] E_CSUM = 2'd1;
  localparam logic [1:0] E_LEN  = 2'd2;
  localparam logic [1:0] E_TYPE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic        nib_q, nib_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] ela_q, ela_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rec_done_q, rec_done_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [7:0]  data_buf_q [MAX_LEN];
  logic             buf_we;
  logic [IDX_W-1:0] buf_widx;
  logic [7:0]       buf_wdata;

  logic        in_vld;
  logic [7:0]  in_byte;
  logic [4:0]  hx;
  logic [7:0]  byte_val;
  logic [7:0]  sum_new;

  // Returns {is_hex, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      return {1'b1, t[3:0]};
    end
    return 5'b0;
  endfunction

  // Bytes arriving while flushing are parked and replayed once back in IDLE
  always_comb begin
    in_vld     = 1'b0;
    in_byte    = rx_data_i;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (state_q == S_FLUSH) begin
      if (rx_valid_i) begin
        hold_d     = rx_data_i;
        hold_vld_d = 1'b1;
      end
    end else if (hold_vld_q) begin
      in_vld     = 1'b1;
      in_byte    = hold_q;
      hold_vld_d = rx_valid_i;
      if (rx_valid_i) hold_d = rx_data_i;
    end else begin
      in_vld = rx_valid_i;
    end
  end

  assign hx       = hex_decode(in_byte);
  assign byte_val = {hi_q, hx[3:0]};
  assign sum_new  = sum_q + byte_val;

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    hi_d       = hi_q;
    len_d      = len_q;
    addr_d     = addr_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    ela_d      = ela_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rec_done_d = 1'b0;
    eof_d      = eof_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;
    buf_widx   = cnt_q[IDX_W-1:0];
    buf_wdata  = byte_val;

    case (state_q)
      S_IDLE: begin
        if (in_vld && in_byte == CH_COLON) begin
          state_d = S_LEN;
          sum_d   = 8'h00;
          nib_d   = 1'b0;
          eof_d   = 1'b0;
        end
      end
      S_FLUSH: begin
        if (cnt_q < len_q) begin
          wr_en_d   = 1'b1;
          wr_data_d = data_buf_q[cnt_q[IDX_W-1:0]];
          wr_addr_d = {ela_q, addr_q + {8'h00, cnt_q}};
          cnt_d     = cnt_q + 8'd1;
        end else begin
          rec_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        if (in_vld) begin
          if (in_byte == CH_COLON) begin
            err_d      = 1'b1;
            err_code_d = E_CHAR;
            state_d    = S_LEN;
            sum_d      = 8'h00;
            nib_d      = 1'b0;
            eof_d      = 1'b0;
          end else if (!hx[4]) begin
            err_d      = 1'b1;
            err_code_d = E_CHAR;
            state_d    = S_IDLE;
            nib_d      = 1'b0;
          end else if (!nib_q) begin
            hi_d  = hx[3:0];
            nib_d = 1'b1;
          end else begin
            nib_d = 1'b0;
            sum_d = sum_new;
            case (state_q)
              S_LEN: begin
                if (int'(byte_val) > MAX_LEN) begin
                  err_d      = 1'b1;
                  err_code_d = E_LEN;
                  state_d    = S_IDLE;
                end else begin
                  len_d   = byte_val;
                  cnt_d   = 8'd0;
                  state_d = S_ADDR;
                end
              end
              S_ADDR: begin
                if (cnt_q == 8'd0) begin
                  addr_d[15:8] = byte_val;
                  cnt_d        = 8'd1;
                end else begin
                  addr_d[7:0] = byte_val;
                  state_d     = S_TYPE;
                end
              end
              S_TYPE: begin
                if (byte_val > 8'h05) begin
                  err_d      = 1'b1;
                  err_code_d = E_TYPE;
                  state_d    = S_IDLE;
                end else if ((byte_val == 8'h01 && len_q != 8'd0) ||
                             (byte_val == 8'h04 && len_q != 8'd2)) begin
                  err_d      = 1'b1;
                  err_code_d = E_LEN;
                  state_d    = S_IDLE;
                end else begin
                  type_d  = byte_val;
                  cnt_d   = 8'd0;
                  state_d = (len_q == 8'd0) ? S_CSUM : S_DATA;
                end
              end
              S_DATA: begin
                buf_we = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == len_q) state_d = S_CSUM;
              end
              S_CSUM: begin
                if (sum_new != 8'h00) begin
                  err_d      = 1'b1;
                  err_code_d = E_CSUM;
                  state_d    = S_IDLE;
                end else if (type_q == 8'h00 && len_q != 8'd0) begin
                  // First write leaves on the cycle right after the final digit
                  wr_en_d   = 1'b1;
                  wr_data_d = data_buf_q[0];
                  wr_addr_d = {ela_q, addr_q};
                  cnt_d     = 8'd1;
                  state_d   = S_FLUSH;
                end else begin
                  if (type_q == 8'h04) ela_d = {data_buf_q[0], data_buf_q[1]};
                  if (type_q == 8'h01) eof_d = 1'b1;
                  rec_done_d = 1'b1;
                  state_d    = S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK_UART_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      nib_q      <= 1'b0;
      hi_q       <= 4'h0;
      len_q      <= 8'h00;
      addr_q     <= 16'h0000;
      type_q     <= 8'h00;
      cnt_q      <= 8'h00;
      sum_q      <= 8'h00;
      ela_q      <= 16'h0000;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'h0;
      wr_data_q  <= 8'h00;
      rec_done_q <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      ela_q      <= ela_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rec_done_q <= rec_done_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge CLK_UART_i) begin
    if (buf_we) data_buf_q[buf_widx] <= buf_wdata;
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rec_done_o = rec_done_q;
  assign eof_o      = eof_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex_record_parser.sv
// Scoreboard bench for hex_record_parser: directed HEX records with hand-computed
// writes/done/error events, checked by an independent output monitor.
module tb_hex_record_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        rec_done_o;
  logic        eof_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;

  hex_record_parser #(.MAX_LEN(16)) dut (
    .CLK_UART_i (clk),
    .rst_n_i    (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .rec_done_o (rec_done_o),
    .eof_o      (eof_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int strobe_cyc = 0;
  int total = 0;
  int bad = 0;

  localparam logic [1:0] K_WR = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  dly;
    logic [31:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input int d, input logic [31:0] a, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.dly  = 8'(d);
    e.addr = a;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data    = b;
    rx_valid   = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input int post);
    for (int i = 0; i < s.len(); i++) send_byte(s.getc(i));
    repeat (post) @(posedge clk);
    #1;
  endtask

  // Monitor: every output event is matched against the head of the queue,
  // including its delay relative to the most recent input strobe.
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (rst_n && (wr_en_o || rec_done_o || err_o)) begin
      act.kind = wr_en_o ? K_WR : (rec_done_o ? K_DONE : K_ERR);
      act.dly  = 8'(cyc - strobe_cyc);
      act.addr = wr_en_o ? wr_addr_o : 32'h0;
      act.data = wr_en_o ? wr_data_o : (err_o ? {6'd0, err_code_o} : 8'h00);
      check("err_done_exclusive", 64'(err_o & rec_done_o), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",    64'(wr_en_o),    64'd0);
    check("rst_wr_addr",  64'(wr_addr_o),  64'd0);
    check("rst_wr_data",  64'(wr_data_o),  64'd0);
    check("rst_rec_done", 64'(rec_done_o), 64'd0);
    check("rst_eof",      64'(eof_o),      64'd0);
    check("rst_err",      64'(err_o),      64'd0);
    check("rst_err_code", 64'(err_code_o), 64'd0);
    check("rst_busy",     64'(busy_o),     64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic data record, three contiguous writes then done
    push(K_WR, 1, 32'h0000_0030, 8'h02);
    push(K_WR, 2, 32'h0000_0031, 8'h33);
    push(K_WR, 3, 32'h0000_0032, 8'h7A);
    push(K_DONE, 4, 32'h0, 8'h00);
    send_str(":03", 0);
    check("busy_mid_record", 64'(busy_o), 64'd1);
    send_str("00300002337A1E", 25);
    check("busy_after_record", 64'(busy_o), 64'd0);
    check("eof_after_data", 64'(eof_o), 64'd0);

    // Extended linear address then a record whose offset wraps
    push(K_DONE, 1, 32'h0, 8'h00);
    send_str(":020000040001F9", 10);
    push(K_WR, 1, 32'h0001_FFFF, 8'hAA);
    push(K_WR, 2, 32'h0001_0000, 8'hBB);
    push(K_DONE, 3, 32'h0, 8'h00);
    send_str(":02FFFF00AABB9B", 25);

    // Bad checksum, then a good record
    push(K_ERR, 1, 32'h0, 8'h01);
    send_str(":0300300002337A1F", 10);
    check("err_code_held_csum", 64'(err_code_o), 64'd1);
    push(K_WR, 1, 32'h0001_0010, 8'h55);
    push(K_DONE, 2, 32'h0, 8'h00);
    send_str(":01001000559A", 25);

    // Character errors: non-hex, and ':' restarting the record
    push(K_ERR, 1, 32'h0, 8'h00);
    send_str(":03003G", 10);
    check("busy_after_char_err", 64'(busy_o), 64'd0);
    push(K_ERR, 1, 32'h0, 8'h00);
    push(K_DONE, 1, 32'h0, 8'h00);
    send_str(":0300:00000001FF", 10);
    check("eof_set", 64'(eof_o), 64'd1);

    // Length and type errors, CR/LF between records
    push(K_ERR, 1, 32'h0, 8'h02);
    send_str(":110000", 10);
    check("eof_cleared_by_colon", 64'(eof_o), 64'd0);
    push(K_ERR, 1, 32'h0, 8'h03);
    send_str(":00000006FA", 10);
    push(K_DONE, 1, 32'h0, 8'h00);
    send_str("\r\n:020000021000EC\r\n", 10);
    check("err_code_held_type", 64'(err_code_o), 64'd3);

    // Reset in the middle of a 16-byte flush
    push(K_WR, 1, 32'h0001_0000, 8'h00);
    send_str(":10000000000102030405060708090A0B0C0D0E0F7", 0);
    @(posedge clk); #1;
    rx_data    = 8'h38;
    rx_valid   = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_async_busy",  64'(busy_o),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(K_WR, 1, 32'h0000_0010, 8'h55);
    push(K_DONE, 2, 32'h0, 8'h00);
    send_str(":01001000559A", 25);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_record_parser.md
# hex_record_parser

Receive-side Intel HEX decoder for the PIC programmer datapath. It consumes the ASCII byte stream delivered by the UART receiver and parses `:LLAAAATT[DD..]CC` records. It verifies each record's checksum, then emits the data bytes as addressed write strobes toward the single-port data memory. It is the counterpart of the block that holds records in memory for transmission: that block turns memory into HEX records; this one turns HEX records into memory writes.

## Interface
- MAX_LEN, 16, maximum data bytes per record (internal buffer depth); 1..255
- CLK_UART_i  in  1  system/UART clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- rx_data_i  in  8  received ASCII byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- wr_en_o  out  1  write strobe, one byte per cycle
- wr_addr_o  out  32  {ext_linear_addr[15:0], offset[15:0]}
- wr_data_o  out  8  data byte
- rec_done_o  out  1  one-cycle pulse, record accepted (checksum good)
- eof_o  out  1  level, type-01 record accepted
- err_o  out  1  one-cycle pulse, record rejected
- err_code_o  out  2  0 CHAR, 1 CSUM, 2 LEN, 3 TYPE; held until next err_o
- busy_o  out  1  high in any state except IDLE

## Operation
- One clock domain; reset is asynchronous, active-low. All outputs reset to 0; the ELA register resets to 0000.
- States:
  - IDLE, LEN, ADDR, TYPE, DATA, CSUM, FLUSH.
  - Each field is assembled from ASCII hex digits (0-9, A-F, a-f), high nibble first, using a nibble-phase flag.
- IDLE:
  - ':' goes to LEN, clears the running sum and clears eof_o.
  - CR, LF and all other characters are ignored.
- LEN:
  - One byte.
  - If LEN > MAX_LEN: err LEN, go to IDLE.
- ADDR: two bytes, big-endian offset.
- TYPE: one byte.
  - 00 data, 01 EOF, 04 ext linear address, 02/03/05 accepted but ignored.
  - Any other type: err TYPE, go to IDLE.
  - Type 01 requires LEN = 0, and type 04 requires LEN = 2; otherwise err LEN.
  - If LEN = 0, go straight to CSUM.
- DATA: LEN bytes written into the buffer in index order.
- CSUM:
  - One byte. The 8-bit sum of all record bytes, including CC, must equal 00; otherwise err CSUM, go to IDLE, and issue no writes.
  - On a good sum:
    - type 00 with LEN > 0 goes to FLUSH;
    - type 04 loads ELA = {D0,D1};
    - type 01 sets eof_o;
    - every other case pulses rec_done_o and goes to IDLE.
- FLUSH:
  - Byte i goes out with wr_addr_o = {ELA, (AAAA+i) mod 2^16}; the offset wraps and ELA is not incremented.
  - After the last byte, pulse rec_done_o and go to IDLE.
- Error conditions:
  - A non-hex character in LEN..CSUM gives err CHAR, go to IDLE.
  - ':' in LEN..CSUM gives err CHAR, then restarts at LEN; that ':' is consumed as a new start.
- A byte arriving during FLUSH is captured in a one-entry holding register and processed in the cycle after FLUSH ends.
  - A second byte arriving during the same FLUSH overwrites the held byte; this cannot occur at UART rates for MAX_LEN ≤ 255.
- Reset mid-record:
  - Returns to IDLE immediately and deasserts wr_en_o.
  - The buffer is discarded and ELA is cleared.

## Timing
- Each rx_valid_i byte is registered; the state/field update is visible the next cycle.
- Error latency: err_o pulses, and err_code_o updates, in the cycle after the offending byte's strobe.
- Data-record latency:
  - Let c be the cycle of the final CC digit strobe.
  - wr_en_o is high for cycles c+1 .. c+LEN, contiguous.
  - rec_done_o pulses at c+LEN+1.
- Non-data records: rec_done_o pulses at c+1.
- wr_addr_o and wr_data_o are valid only while wr_en_o is high; they hold their last value otherwise.
- err_o and rec_done_o are never asserted in the same cycle.
- Throughput: one write per cycle; a record needs 11+2·LEN characters.

## Test plan
- ":0300300002337A1E" -> writes 00000030=02, 00000031=33, 00000032=7A on 3 consecutive cycles; rec_done_o at c+4; err_o never high.
- ":020000040001F9" then ":02FFFF00AABB9B" -> rec_done_o after the first record with no write; then writes 0001FFFF=AA and 00010000=BB (offset wraps, ELA stays 0001).
- ":0300300002337A1F" -> err_o with err_code_o=1; no wr_en_o; next valid record parses normally.
- ":03003G" and ":0300:00000001FF" ->
  - first: err_code_o=0 on the 'G';
  - second: err_code_o=0 on the inner ':', then eof_o=1 after FF.
- LEN=MAX_LEN+1 (":11...") -> err_code_o=2 on the LEN byte; ":00000006FA" -> err_code_o=3; CR/LF between records produce no error.
- rst_n_i low during FLUSH of a 16-byte record -> wr_en_o=0 asynchronously, busy_o=0; after release, a fresh record writes with ELA=0000.
